// File: rtl/end_generate.sv
// UDP receive stage: strips the 8-byte header and forwards payload of datagrams whose ports match; 0-cycle latency, no backpressure.
// Optional END_GENERATE_LAST_EN adds last_o flagging the final payload beat.
module end_generate #(
    parameter int              DATA_W   = 16,
    parameter int              LEN_W    = 2,
    parameter int              PORT_W   = 16,
    parameter logic [PORT_W-1:0] SRC_PORT = 16'd18070,
    parameter logic [PORT_W-1:0] DST_PORT = 16'd18070
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              ip_cs_err_i,
    output logic              valid_o,
    output logic              start_o,
    output logic [DATA_W-1:0] data_o,
`ifdef END_GENERATE_LAST_EN
    output logic              last_o,
`endif
    output logic [LEN_W-1:0]  len_o
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        HEAD = 3'b010,
        DATA = 3'b100
    } state_t;

    state_t      state_q;
    logic        drop_q;
    logic        first_q;
    logic [15:0] cnt_q;
    logic [15:0] udp_len_q;

    logic [15:0] field;
    logic [15:0] len_ext;
    logic [15:0] cnt_sum;
    logic        last_beat;
    logic        fwd;

    // Wire order is data_i[7:0] first, so swap bytes to get the big-endian field.
    assign field     = {data_i[7:0], data_i[15:8]};
    assign len_ext   = {{(16-LEN_W){1'b0}}, len_i};
    assign cnt_sum   = cnt_q + len_ext;
    assign last_beat = (cnt_sum >= udp_len_q);

    assign fwd = nreset & valid_i & ~cancel_i & ~start_i & (state_q == DATA)
               & ~(drop_q | ip_cs_err_i);

    assign valid_o = fwd;
    assign start_o = fwd & first_q;
    assign data_o  = data_i;
    assign len_o   = len_i;
`ifdef END_GENERATE_LAST_EN
    assign last_o  = fwd & last_beat;
`endif

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= IDLE;
            drop_q    <= 1'b0;
            first_q   <= 1'b0;
            cnt_q     <= '0;
            udp_len_q <= '0;
        end else if (cancel_i) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else if (valid_i) begin
            if (start_i) begin
                // A start beat always restarts parsing, aborting any datagram in flight.
                state_q <= HEAD;
                cnt_q   <= len_ext;
                drop_q  <= (field != SRC_PORT) | ip_cs_err_i;
                first_q <= 1'b0;
            end else begin
                case (state_q)
                    HEAD: begin
                        cnt_q <= cnt_sum;
                        if (cnt_q == 16'd2)
                            drop_q <= drop_q | ip_cs_err_i | (field != DST_PORT);
                        else
                            drop_q <= drop_q | ip_cs_err_i;
                        if (cnt_q == 16'd4)
                            udp_len_q <= field;
                        if (cnt_sum >= 16'd8) begin
                            if (udp_len_q <= 16'd8) begin
                                state_q <= IDLE;
                                if (udp_len_q < 16'd8)
                                    drop_q <= 1'b1;
                            end else begin
                                state_q <= DATA;
                                first_q <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        cnt_q   <= cnt_sum;
                        first_q <= 1'b0;
                        drop_q  <= drop_q | ip_cs_err_i;
                        if (last_beat)
                            state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_end_generate.sv
// Scoreboard bench for end_generate: stimulus pushes expected payload beats, a negedge monitor pops and compares.
module tb_end_generate;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cancel_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [1:0]  len_i = '0;
    logic        ip_cs_err_i = 1'b0;
    logic        valid_o;
    logic        start_o;
    logic [15:0] data_o;
    logic [1:0]  len_o;
    logic        last_w;

    end_generate dut (
        .clk         (clk),
        .nreset      (nreset),
        .cancel_i    (cancel_i),
        .valid_i     (valid_i),
        .start_i     (start_i),
        .data_i      (data_i),
        .len_i       (len_i),
        .ip_cs_err_i (ip_cs_err_i),
        .valid_o     (valid_o),
        .start_o     (start_o),
        .data_o      (data_o),
`ifdef END_GENERATE_LAST_EN
        .last_o      (last_w),
`endif
        .len_o       (len_o)
    );

`ifndef END_GENERATE_LAST_EN
    assign last_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic        s;
        logic [15:0] d;
        logic [1:0]  l;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (valid_o) begin
            exp_t e;
            exp_t a;
            checks++;
            a = '{s: start_o, d: data_o, l: len_o, last: last_w};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got start=%0b data=%h len=%0d, required no valid_o", start_o, data_o, len_o);
            end else begin
                e = exp_q.pop_front();
`ifndef END_GENERATE_LAST_EN
                e.last = 1'b0;
`endif
                if (a !== e) begin
                    errors++;
                    $display("FAIL beat: got start=%0b data=%h len=%0d last=%0b, required start=%0b data=%h len=%0d last=%0b",
                             a.s, a.d, a.l, a.last, e.s, e.d, e.l, e.last);
                end
            end
        end
    end

    function automatic logic [15:0] w(input logic [15:0] f);
        return {f[7:0], f[15:8]};
    endfunction

    task automatic beat(input logic s, input logic [15:0] d, input logic [1:0] l, input logic err,
                        input logic can, input logic ex, input logic ex_s, input logic ex_last);
        @(posedge clk);
        #1;
        valid_i = 1'b1; start_i = s; data_i = d; len_i = l; ip_cs_err_i = err; cancel_i = can;
        if (ex) exp_q.push_back('{s: ex_s, d: d, l: l, last: ex_last});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0; ip_cs_err_i = 1'b0; data_i = '0;
    endtask

    task automatic hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] ulen);
        beat(1'b1, w(src), 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, w(dst), 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, w(ulen), 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 16'h5A5A, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Good 2-beat datagram used to prove recovery after each corner case.
    task automatic good(input logic [15:0] a, input logic [15:0] b);
        hdr(16'h4696, 16'h4696, 16'd12);
        beat(1'b0, a, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        beat(1'b0, b, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || start_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: got valid_o=%0b start_o=%0b, required 0/0", name, valid_o, start_o);
        end
    endtask

    initial begin
        // Reset with a start beat presented: outputs must stay low.
        valid_i = 1'b1; start_i = 1'b1; data_i = w(16'h4696); len_i = 2'd2;
        check_quiet("reset_outputs");
        repeat (2) @(posedge clk);
        #1; nreset = 1'b1; valid_i = 1'b0; start_i = 1'b0;
        idle();

        // Good datagram
        good(16'hBBAA, 16'hDDCC);
        idle();

        // Odd length, then an immediate new datagram
        hdr(16'h4696, 16'h4696, 16'd11);
        beat(1'b0, 16'h2211, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        beat(1'b0, 16'h0033, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        good(16'h4455, 16'h6677);
        idle();

        // Source port mismatch, destination port mismatch, then good
        hdr(16'h1234, 16'h4696, 16'd12);
        beat(1'b0, 16'h1111, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 16'h2222, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hdr(16'h4696, 16'h4697, 16'd12);
        beat(1'b0, 16'h3333, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 16'h4444, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        good(16'h8899, 16'hAABB);
        idle();

        // IP checksum error on the second of three payload beats
        hdr(16'h4696, 16'h4696, 16'd14);
        beat(1'b0, 16'hC001, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        beat(1'b0, 16'hC002, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 16'hC003, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        good(16'hCCDD, 16'hEEFF);
        idle();

        // Cancel mid-DATA; the leftover beat is ignored in IDLE
        hdr(16'h4696, 16'h4696, 16'd14);
        beat(1'b0, 16'hD001, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        beat(1'b0, 16'hD002, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 16'hD003, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        good(16'h0102, 16'h0304);
        idle();

        // Restart via start_i mid-DATA
        hdr(16'h4696, 16'h4696, 16'd14);
        beat(1'b0, 16'hE001, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        good(16'h0506, 16'h0708);
        idle();

        // Reset mid-DATA
        hdr(16'h4696, 16'h4696, 16'd14);
        beat(1'b0, 16'hF001, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1; nreset = 1'b0; valid_i = 1'b1; start_i = 1'b0; data_i = 16'hF002; len_i = 2'd2;
        check_quiet("reset_mid_data");
        @(posedge clk);
        #1; nreset = 1'b1;
        beat(1'b0, 16'hF003, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        good(16'h090A, 16'h0B0C);
        idle();

        // Zero payload, stray beat ignored, then good
        hdr(16'h4696, 16'h4696, 16'd8);
        beat(1'b0, 16'h7777, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        good(16'h1357, 16'h2468);
        idle();

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_beats: got %0d beats outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/end_generate.md
Name: end_generate

Overview:
- UDP receive stage sitting between the IPv4 receive block and the application layer, with a 16-bit datapath.
- Parses the 8-byte UDP header and checks the source and destination ports against fixed parameters.
- Forwards only the payload beats of matching datagrams. Datagrams with a port mismatch or an IP checksum error are discarded.
- No UDP checksum check is performed; this is legal for IPv4.

Parameters:
- DATA_W, 16: datapath width in bits. Only 16 is supported.
- LEN_W, 2: width of the byte-count field. Encodes 1 or 2 valid bytes per beat.
- PORT_W, 16: UDP port width.
- SRC_PORT, 16'd18070 (0x4696): required UDP source port.
- DST_PORT, 16'd18070 (0x4696): required UDP destination port.

Ports:
- clk  in  1  clock
- nreset  in  1  reset; synchronous, active-low
- cancel_i  in  1  abort the current datagram
- valid_i  in  1  input beat valid
- start_i  in  1  first beat of the IP payload, i.e. the first UDP header beat
- data_i  in  16  payload bytes; data_i[7:0] is the earlier byte on the wire
- len_i  in  2  valid bytes in the beat (1 or 2). With 1, only data_i[7:0] is valid.
- ip_cs_err_i  in  1  IP header checksum error, qualified by valid_i
- valid_o  out  1  output payload beat valid
- start_o  out  1  first payload beat of the datagram
- data_o  out  16  payload data
- len_o  out  2  valid bytes in the output beat

Behaviour:
- Reset is synchronous on nreset=0. State becomes IDLE and drop, cnt and first are cleared. valid_o and start_o are 0 while in reset.
- data_o = data_i and len_o = len_i, combinational pass-through. Latency is 0 cycles; there is no backpressure.
- Multi-byte fields are big-endian: field = {data_i[7:0], data_i[15:8]}.
- Header beat order: source port, destination port, length, checksum. The checksum beat is ignored.
- cnt is a 16-bit byte counter for the datagram, updated by +len_i on each valid beat.
- udp_len is a 16-bit register captured from the length beat. It counts header plus payload bytes.
- All state only advances on a cycle where valid_i=1, except cancel_i, which acts every cycle.

FSM states: IDLE, HEAD, DATA (one-hot).
- IDLE with valid_i & start_i:
  - cnt = len_i.
  - drop = (src_port != SRC_PORT) | ip_cs_err_i.
  - Next state HEAD.
- IDLE with valid_i & ~start_i: beat ignored.
- HEAD: each valid beat adds len_i to cnt.
  - At cnt 2 (destination port beat): drop |= (port != DST_PORT).
  - At cnt 4: capture udp_len.
  - When cnt+len_i reaches 8, go to DATA and set first=1.
  - Exception: if udp_len <= 8, go to IDLE instead. udp_len < 8 additionally sets drop; there is no payload either way.
- DATA, per valid beat:
  - valid_o = ~drop_eff.
  - start_o = valid_o & first; first clears after the first valid beat.
  - When cnt+len_i >= udp_len, this is the last beat; go to IDLE.
- drop_eff = drop | ip_cs_err_i on the current beat. The error suppresses the current beat and every later beat of the datagram.
- Beats already forwarded before an error are not recalled.
- drop clears when the next datagram starts.
- start_i with valid_i in HEAD or DATA aborts the current datagram (no further valid_o for it) and restarts parsing that beat as a new header beat.
- cancel_i=1: valid_o = start_o = 0 in that cycle, and the state goes to IDLE at the next clock, regardless of valid_i.
- cancel_i has priority over start_i.
- Length arithmetic wraps at 16 bits, with the overflow bit ignored.

Optional Feature:
- END_GENERATE_LAST_EN defined: adds output last_o (1 bit).
  - last_o = valid_o on the final payload beat of the datagram, i.e. where cnt+len_i >= udp_len.
  - len_o on that beat equals the remaining byte count.
- Not defined: last_o does not exist. All other behaviour is identical.

Test Plan:
- Good datagram:
  - Stimulus: ports 0x4696/0x4696, udp_len=12, payload 0xBBAA, 0xDDCC.
  - Response: valid_o on exactly 2 beats with data_o=0xBBAA then 0xDDCC; start_o only on the first; len_o=2 on both.
  - With the feature enabled, last_o on the second beat.
- Odd length:
  - Stimulus: udp_len=11, payload beats len 2 then len 1.
  - Response: 2 output beats, the last with len_o=1.
  - The FSM is back in IDLE and accepts a new start_i on the next valid beat.
- Port mismatch:
  - Stimulus 1: source port 0x1234 (beat 0x3412). Stimulus 2: destination port mismatch.
  - Response: valid_o=0 for the whole datagram.
  - A following good datagram is forwarded normally.
- IP checksum error:
  - Stimulus: ip_cs_err_i=1 on the second payload beat of a 3-payload-beat datagram.
  - Response: beat 1 forwarded; beats 2 and 3 suppressed.
- Cancel and reset:
  - Stimulus: cancel_i mid-DATA, then a new datagram. Separately, nreset=0 mid-DATA.
  - Response: valid_o drops immediately; the next start_i parses correctly; after reset valid_o=0 until a new good header.
- Zero payload:
  - Stimulus: udp_len=8.
  - Response: no valid_o; IDLE after the checksum beat.
